ext_trigger_ctrl: RTL and testbench

EXT_TRIGGER_CTRL -- requirements
Module: ext_trigger_ctrl

---
 rtl/ext_trigger_ctrl.sv | 154 +++++++++++++++
 tb/tb_ext_trigger_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_trigger_ctrl.sv
// External/soft trigger session controller: arms, delays, fires the sequencer,
// waits for run completion, applies holdoff and repeats until the session ends.
module ext_trigger_ctrl (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        pulse_detected,
  input  logic        soft_trigger,
  input  logic        arm,
  input  logic        abort,
  input  logic [31:0] delay_cycles,
  input  logic [31:0] holdoff_cycles,
  input  logic [31:0] timeout_cycles,
  input  logic [15:0] repeat_count,
  input  logic        seq_done,
  output logic        seq_start,
  output logic        armed,
  output logic        busy,
  output logic [2:0]  state,
  output logic        session_done,
  output logic        timeout_flag,
  output logic [15:0] trigger_count,
  output logic [15:0] missed_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_FIRE    = 3'd3,
    S_RUN     = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t      cur_st, nxt_st;
  logic        pd_q;
  logic        trig_evt;
  logic [31:0] dly_sh, hold_sh, tmo_sh;
  logic [15:0] rem_runs;
  logic [31:0] wait_cnt;
  logic        do_arm, accept, miss, tmo_hit, last_run, run_more;

  assign trig_evt = (pulse_detected & ~pd_q) | soft_trigger;

  always_comb begin
    nxt_st   = cur_st;
    do_arm   = 1'b0;
    accept   = 1'b0;
    miss     = 1'b0;
    tmo_hit  = 1'b0;
    last_run = 1'b0;
    run_more = 1'b0;
    if (abort) begin
      nxt_st = S_IDLE;
    end else begin
      case (cur_st)
        S_IDLE: begin
          if (arm) begin
            do_arm = 1'b1;
            nxt_st = S_ARMED;
          end
        end
        S_ARMED: begin
          // A trigger landing on the expiry cycle wins over the timeout.
          if (trig_evt) begin
            accept = 1'b1;
            nxt_st = (dly_sh != 32'd0) ? S_DELAY : S_FIRE;
          end else if ((tmo_sh != 32'd0) && (wait_cnt == tmo_sh - 32'd1)) begin
            tmo_hit = 1'b1;
            nxt_st  = S_IDLE;
          end
        end
        S_DELAY: begin
          miss = trig_evt;
          if (wait_cnt == 32'd0) nxt_st = S_FIRE;
        end
        S_FIRE: begin
          miss   = trig_evt;
          nxt_st = S_RUN;
        end
        S_RUN: begin
          miss = trig_evt;
          if (seq_done) begin
            if (rem_runs == 16'd1) begin
              last_run = 1'b1;
              nxt_st   = S_IDLE;
            end else begin
              run_more = 1'b1;
              nxt_st   = (hold_sh != 32'd0) ? S_HOLDOFF : S_ARMED;
            end
          end
        end
        S_HOLDOFF: begin
          miss = trig_evt;
          if (wait_cnt == 32'd0) nxt_st = S_ARMED;
        end
        default: nxt_st = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cur_st        <= S_IDLE;
      pd_q          <= 1'b0;
      wait_cnt      <= 32'd0;
      rem_runs      <= 16'd0;
      timeout_flag  <= 1'b0;
      trigger_count <= 16'd0;
      missed_count  <= 16'd0;
    end else begin
      cur_st <= nxt_st;
      pd_q   <= pulse_detected;
      // One down/up counter serves delay, holdoff and the armed timeout.
      if (nxt_st != cur_st) begin
        case (nxt_st)
          S_DELAY:   wait_cnt <= dly_sh - 32'd1;
          S_HOLDOFF: wait_cnt <= hold_sh - 32'd1;
          default:   wait_cnt <= 32'd0;
        endcase
      end else if (cur_st == S_DELAY || cur_st == S_HOLDOFF) begin
        wait_cnt <= wait_cnt - 32'd1;
      end else if (cur_st == S_ARMED) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
      if (do_arm) begin
        rem_runs      <= repeat_count;
        timeout_flag  <= 1'b0;
        trigger_count <= 16'd0;
        missed_count  <= 16'd0;
      end else begin
        if (run_more && rem_runs != 16'd0) rem_runs <= rem_runs - 16'd1;
        if (tmo_hit) timeout_flag <= 1'b1;
        if (accept && trigger_count != 16'hFFFF) trigger_count <= trigger_count + 16'd1;
        if (miss && missed_count != 16'hFFFF) missed_count <= missed_count + 16'd1;
      end
    end
  end

  // Shadow configuration is pure data; it is only meaningful after an arm.
  always_ff @(posedge aclk) begin
    if (do_arm) begin
      dly_sh  <= delay_cycles;
      hold_sh <= holdoff_cycles;
      tmo_sh  <= timeout_cycles;
    end
  end

  assign seq_start    = (cur_st == S_FIRE) && !abort && aresetn;
  assign session_done = last_run && aresetn;
  assign armed        = (cur_st == S_ARMED);
  assign busy         = (cur_st != S_IDLE);
  assign state        = cur_st;

endmodule

// File: tb/tb_ext_trigger_ctrl.sv
// Directed bench for ext_trigger_ctrl: per-scenario tasks with hand-derived
// expected cycles, states and counters.
module tb_ext_trigger_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        pulse_detected, soft_trigger, arm, abort, seq_done;
  logic [31:0] delay_cycles, holdoff_cycles, timeout_cycles;
  logic [15:0] repeat_count;
  logic        seq_start, armed, busy, session_done, timeout_flag;
  logic [2:0]  state;
  logic [15:0] trigger_count, missed_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_start, n_sd, last_start;
  int t0;

  ext_trigger_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .pulse_detected(pulse_detected),
    .soft_trigger(soft_trigger), .arm(arm), .abort(abort),
    .delay_cycles(delay_cycles), .holdoff_cycles(holdoff_cycles),
    .timeout_cycles(timeout_cycles), .repeat_count(repeat_count),
    .seq_done(seq_done), .seq_start(seq_start), .armed(armed), .busy(busy),
    .state(state), .session_done(session_done), .timeout_flag(timeout_flag),
    .trigger_count(trigger_count), .missed_count(missed_count)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (seq_start === 1'b1) begin
      n_start++;
      last_start = cyc;
    end
    if (session_done === 1'b1) n_sd++;
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Leaves the bench in the first ARMED cycle; config inputs are then scrambled.
  task automatic arm_session(input int d, input int h, input int t, input int r);
    delay_cycles   = d;
    holdoff_cycles = h;
    timeout_cycles = t;
    repeat_count   = r[15:0];
    arm = 1'b1;
    step();
    arm = 1'b0;
    delay_cycles   = 32'd7;
    holdoff_cycles = 32'd3;
    timeout_cycles = 32'd2;
    repeat_count   = 16'd9;
    n_start = 0;
    n_sd    = 0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    pulse_detected = 1'b1; soft_trigger = 1'b0; arm = 1'b0; abort = 1'b0; seq_done = 1'b0;
    delay_cycles = 0; holdoff_cycles = 0; timeout_cycles = 0; repeat_count = 0;
    repeat (3) step();
    pulse_detected = 1'b0;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if ({seq_start, armed, busy, session_done, timeout_flag} !== 5'b0) begin bad++;
      $display("FAIL reset_flags got=%b exp=00000", {seq_start, armed, busy, session_done, timeout_flag}); end
    total++; if ({trigger_count, missed_count} !== 32'd0) begin bad++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", trigger_count, missed_count); end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_delay();
    arm_session(10, 0, 0, 1);
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL t1_armed got=%0d exp=1", armed); end
    pulse_detected = 1'b1;
    t0 = cyc;
    step();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL t1_delay_state got=%0d exp=2", state); end
    step();
    pulse_detected = 1'b0;
    repeat (12) step();
    total++; if (n_start !== 1 || last_start !== t0 + 11) begin bad++;
      $display("FAIL t1_start_cycle got=%0d@%0d exp=1@%0d", n_start, last_start - t0, 11); end
    total++; if (state !== 3'd4) begin bad++; $display("FAIL t1_run_state got=%0d exp=4", state); end
    seq_done = 1'b1;
    #1;
    total++; if (session_done !== 1'b1) begin bad++; $display("FAIL t1_session_done got=%0d exp=1", session_done); end
    step();
    seq_done = 1'b0;
    total++; if (state !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL t1_idle got=%0d exp=0", state); end
    total++; if (trigger_count !== 16'd1) begin bad++; $display("FAIL t1_trig_count got=%0d exp=1", trigger_count); end
  endtask

  task automatic test_repeat_holdoff();
    arm_session(0, 5, 0, 3);
    for (int r = 0; r < 3; r++) begin
      soft_trigger = 1'b1;
      step();
      soft_trigger = 1'b0;
      step();
      pulse_detected = 1'b1;
      step();
      pulse_detected = 1'b0;
      step();
      seq_done = 1'b1;
      step();
      seq_done = 1'b0;
      if (r < 2) begin
        total++; if (state !== 3'd5) begin bad++; $display("FAIL t2_holdoff_state r=%0d got=%0d exp=5", r, state); end
        soft_trigger = 1'b1;
        step();
        soft_trigger = 1'b0;
        repeat (4) step();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL t2_rearm r=%0d got=%0d exp=1", r, state); end
      end
    end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL t2_end_state got=%0d exp=0", state); end
    total++; if (n_start !== 3) begin bad++; $display("FAIL t2_starts got=%0d exp=3", n_start); end
    total++; if (missed_count !== 16'd5) begin bad++; $display("FAIL t2_missed got=%0d exp=5", missed_count); end
    total++; if (trigger_count !== 16'd3) begin bad++; $display("FAIL t2_trig got=%0d exp=3", trigger_count); end
    total++; if (n_sd !== 1) begin bad++; $display("FAIL t2_session_done got=%0d exp=1", n_sd); end
  endtask

  task automatic test_timeout();
    arm_session(0, 0, 100, 1);
    repeat (99) step();
    total++; if (state !== 3'd1 || timeout_flag !== 1'b0) begin bad++;
      $display("FAIL t3_cycle100 got=%0d/%0d exp=1/0", state, timeout_flag); end
    step();
    total++; if (state !== 3'd0 || timeout_flag !== 1'b1) begin bad++;
      $display("FAIL t3_expired got=%0d/%0d exp=0/1", state, timeout_flag); end
    arm_session(0, 0, 100, 1);
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL t3_flag_cleared got=%0d exp=0", timeout_flag); end
    repeat (99) step();
    soft_trigger = 1'b1;
    step();
    soft_trigger = 1'b0;
    total++; if (state !== 3'd3 || timeout_flag !== 1'b0) begin bad++;
      $display("FAIL t3_edge_accept got=%0d/%0d exp=3/0", state, timeout_flag); end
    total++; if (trigger_count !== 16'd1) begin bad++; $display("FAIL t3_edge_trig got=%0d exp=1", trigger_count); end
    step();
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    total++; if (state !== 3'd0 || n_start !== 1) begin bad++;
      $display("FAIL t3_edge_done got=%0d/%0d exp=0/1", state, n_start); end
  endtask

  task automatic test_abort();
    arm_session(50, 0, 0, 1);
    soft_trigger = 1'b1;
    step();
    soft_trigger = 1'b0;
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++; if (state !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL t4_abort_idle got=%0d exp=0", state); end
    repeat (60) step();
    total++; if (n_start !== 0) begin bad++; $display("FAIL t4_no_start got=%0d exp=0", n_start); end
    arm_session(2, 0, 0, 1);
    soft_trigger = 1'b1;
    t0 = cyc;
    step();
    soft_trigger = 1'b0;
    repeat (4) step();
    total++; if (n_start !== 1 || last_start !== t0 + 3) begin bad++;
      $display("FAIL t4_rearm_start got=%0d@%0d exp=1@3", n_start, last_start - t0); end
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
    total++; if (state !== 3'd0 || n_sd !== 1) begin bad++; $display("FAIL t4_rearm_done got=%0d/%0d exp=0/1", state, n_sd); end
  endtask

  task automatic test_coincident();
    arm_session(0, 0, 0, 1);
    pulse_detected = 1'b1;
    soft_trigger   = 1'b1;
    t0 = cyc;
    step();
    soft_trigger = 1'b0;
    total++; if (trigger_count !== 16'd1) begin bad++; $display("FAIL t5_trig got=%0d exp=1", trigger_count); end
    total++; if (seq_start !== 1'b1) begin bad++; $display("FAIL t5_start_now got=%0d exp=1", seq_start); end
    step();
    pulse_detected = 1'b0;
    step();
    total++; if (n_start !== 1 || last_start !== t0 + 1) begin bad++;
      $display("FAIL t5_start_cycle got=%0d@%0d exp=1@1", n_start, last_start - t0); end
    total++; if (missed_count !== 16'd0) begin bad++; $display("FAIL t5_missed got=%0d exp=0", missed_count); end
    seq_done = 1'b1;
    step();
    seq_done = 1'b0;
  endtask

  task automatic test_reset_in_run();
    arm_session(0, 0, 0, 2);
    soft_trigger = 1'b1;
    step();
    soft_trigger = 1'b0;
    step();
    total++; if (state !== 3'd4) begin bad++; $display("FAIL t6_run got=%0d exp=4", state); end
    aresetn = 1'b0;
    step();
    total++; if ({state, seq_start, armed, busy, session_done, timeout_flag} !== 8'd0) begin bad++;
      $display("FAIL t6_reset_outs got=%b exp=0", {state, seq_start, armed, busy, session_done, timeout_flag}); end
    total++; if ({trigger_count, missed_count} !== 32'd0) begin bad++;
      $display("FAIL t6_reset_counts got=%0d/%0d exp=0/0", trigger_count, missed_count); end
    aresetn  = 1'b1;
    seq_done = 1'b1;
    #1;
    total++; if (session_done !== 1'b0) begin bad++; $display("FAIL t6_sd_ignored got=%0d exp=0", session_done); end
    step();
    seq_done = 1'b0;
    step();
    total++; if (state !== 3'd0 || n_sd !== 0 || n_start !== 1) begin bad++;
      $display("FAIL t6_after got=%0d/%0d/%0d exp=0/0/1", state, n_sd, n_start); end
  endtask

  initial begin
    n_start = 0;
    n_sd    = 0;
    last_start = 0;
    test_reset();
    test_delay();
    test_repeat_holdoff();
    test_timeout();
    test_abort();
    test_coincident();
    test_reset_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
